// File: rtl/fp_issue_hazard_ctrl.sv
// Decode-stage FPU issue and hazard stall control. fpu_start/stall are combinational;
// the FPU result appears LAT+1 cycles after issue, and stall holds ID until every hazard clears.
module fp_issue_hazard_ctrl #(
  parameter int ADDF_LAT = 2,
  parameter int MULF_LAT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [19:0] id_opcode,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic [3:0]  id_dst,
  input  logic [19:0] ex_opcode,
  input  logic [3:0]  ex_dst,
  output logic        stall,
  output logic        fpu_start,
  output logic        fpu_mul,
  output logic        fpu_busy,
  output logic        fpu_wb_en,
  output logic [3:0]  fpu_wb_dst
);

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  localparam logic [2:0] ADDF_CNT = 3'(ADDF_LAT - 1);
  localparam logic [2:0] MULF_CNT = 3'(MULF_LAT - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic [3:0] pending_dst;
  logic       reads1, reads2, is_fp, is_mul;
  logic       load_use, fp_haz, issue;
  logic       unused_opcode_bits;

  assign unused_opcode_bits = ^{id_opcode[17], id_opcode[15:13], id_opcode[11],
                                ex_opcode[19:3], ex_opcode[1:0]};

  assign reads1 = (|id_opcode[10:0]) | id_opcode[12] | id_opcode[18] | id_opcode[19];
  assign reads2 = id_opcode[0] | id_opcode[1] | id_opcode[3] | id_opcode[4] |
                  id_opcode[5] | id_opcode[6] | id_opcode[18] | id_opcode[19];
  assign is_fp  = id_opcode[18] | id_opcode[19];
  // MULF wins when both FP bits are set
  assign is_mul = id_opcode[19];

  assign load_use = ex_opcode[2] & ((reads1 & (ex_dst == id_src1)) |
                                    (reads2 & (ex_dst == id_src2)));

  assign fp_haz = (state != IDLE) &
                  ((reads1 & (pending_dst == id_src1)) |
                   (reads2 & (pending_dst == id_src2)) |
                   (id_opcode[16] & (pending_dst == id_dst)) |
                   is_fp);

  assign issue = (state == IDLE) & is_fp & ~load_use;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = BUSY;
      BUSY:    if (cnt == 3'd0) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter loads LAT-1 on issue so BUSY spans exactly LAT cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= 3'd0;
      pending_dst <= 4'd0;
    end else if (issue) begin
      cnt         <= is_mul ? MULF_CNT : ADDF_CNT;
      pending_dst <= id_dst;
    end else if ((state == BUSY) && (cnt != 3'd0)) begin
      cnt <= cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpu_busy   <= 1'b0;
      fpu_wb_en  <= 1'b0;
      fpu_wb_dst <= 4'd0;
    end else begin
      fpu_busy   <= (state_nxt != IDLE);
      fpu_wb_en  <= (state_nxt == WB);
      fpu_wb_dst <= (state_nxt == WB) ? pending_dst : 4'd0;
    end
  end

  // Combinational outputs are forced low while reset is asserted
  always_comb begin
    stall     = reset_n & (load_use | fp_haz | (state == WB));
    fpu_start = reset_n & issue;
    fpu_mul   = reset_n & issue & is_mul;
  end

endmodule

// File: tb/tb_fp_issue_hazard_ctrl.sv
// Directed bench for fp_issue_hazard_ctrl; FPU writebacks are scoreboarded against issues.
module tb_fp_issue_hazard_ctrl;

  localparam logic [19:0] OP_NONE  = 20'h00000;
  localparam logic [19:0] OP_ADD   = 20'h10001;
  localparam logic [19:0] OP_ADDNW = 20'h00001;
  localparam logic [19:0] OP_SUB   = 20'h10002;
  localparam logic [19:0] OP_LOAD  = 20'h10004;
  localparam logic [19:0] OP_NOP   = 20'h00800;
  localparam logic [19:0] OP_MOVE  = 20'h11000;
  localparam logic [19:0] OP_MOVEI = 20'h12000;
  localparam logic [19:0] OP_ADDF  = 20'h50000;
  localparam logic [19:0] OP_MULF  = 20'h90000;
  localparam logic [19:0] OP_BOTHF = 20'hD0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [19:0] id_opcode, ex_opcode;
  logic [3:0]  id_src1, id_src2, id_dst, ex_dst;
  logic        stall, fpu_start, fpu_mul, fpu_busy, fpu_wb_en;
  logic [3:0]  fpu_wb_dst;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] sb[$];

  always #5 clk = ~clk;

  fp_issue_hazard_ctrl #(.ADDF_LAT(2), .MULF_LAT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_opcode(id_opcode), .id_src1(id_src1), .id_src2(id_src2), .id_dst(id_dst),
    .ex_opcode(ex_opcode), .ex_dst(ex_dst),
    .stall(stall), .fpu_start(fpu_start), .fpu_mul(fpu_mul), .fpu_busy(fpu_busy),
    .fpu_wb_en(fpu_wb_en), .fpu_wb_dst(fpu_wb_dst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_id(input logic [19:0] op, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] d);
    id_opcode = op; id_src1 = s1; id_src2 = s2; id_dst = d;
  endtask

  task automatic set_ex(input logic [19:0] op, input logic [3:0] d);
    ex_opcode = op; ex_dst = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_start"}, 32'(fpu_start), 0);
    chk({tag, "_mul"}, 32'(fpu_mul), 0);
    chk({tag, "_busy"}, 32'(fpu_busy), 0);
    chk({tag, "_wb_en"}, 32'(fpu_wb_en), 0);
    chk({tag, "_wb_dst"}, 32'(fpu_wb_dst), 0);
  endtask

  // Writeback monitor: every fpu_wb_en must match the oldest outstanding issue
  always @(negedge clk) begin
    if (fpu_wb_en === 1'b1) begin
      n_tests++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL wb_unexpected: observed dst %0d expected no writeback", fpu_wb_dst);
      end
      if (sb.size() > 0) chk("wb_dst_sb", 32'(fpu_wb_dst), 32'(sb.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    set_ex(OP_LOAD, 4'd7);
    set_id(OP_SUB, 4'd0, 4'd7, 4'd1);
    #2;
    chk_all_zero("reset");
    #10;
    reset_n = 1'b1;
    set_ex(OP_NONE, 4'd0);
    set_id(OP_NONE, 4'd0, 4'd0, 4'd0);

    // MULF latency with an independent ADD behind it
    nxt(); set_id(OP_MULF, 4'd1, 4'd2, 4'd5);
    mid();
    chk("mulf_start", 32'(fpu_start), 1);
    chk("mulf_sel", 32'(fpu_mul), 1);
    chk("mulf_c0_stall", 32'(stall), 0);
    chk("mulf_c0_busy", 32'(fpu_busy), 0);
    if (fpu_start === 1'b1) sb.push_back(4'd5);
    nxt(); set_id(OP_ADD, 4'd1, 4'd2, 4'd3);
    for (int c = 1; c <= 4; c++) begin
      mid();
      chk($sformatf("mulf_c%0d_busy", c), 32'(fpu_busy), 1);
      chk($sformatf("mulf_c%0d_stall", c), 32'(stall), 0);
      chk($sformatf("mulf_c%0d_wb", c), 32'(fpu_wb_en), 0);
      chk($sformatf("mulf_c%0d_start", c), 32'(fpu_start), 0);
      nxt();
    end
    mid();
    chk("mulf_c5_busy", 32'(fpu_busy), 1);
    chk("mulf_c5_wb", 32'(fpu_wb_en), 1);
    chk("mulf_c5_dst", 32'(fpu_wb_dst), 5);
    chk("mulf_c5_stall", 32'(stall), 1);
    nxt();
    mid();
    chk("mulf_c6_busy", 32'(fpu_busy), 0);
    chk("mulf_c6_stall", 32'(stall), 0);

    // RAW on the pending ADDF destination
    nxt(); set_id(OP_ADDF, 4'd1, 4'd3, 4'd2);
    mid();
    chk("raw_start", 32'(fpu_start), 1);
    chk("raw_sel", 32'(fpu_mul), 0);
    if (fpu_start === 1'b1) sb.push_back(4'd2);
    nxt(); set_id(OP_ADD, 4'd2, 4'd0, 4'd6);
    for (int c = 1; c <= 3; c++) begin
      mid();
      chk($sformatf("raw_c%0d_stall", c), 32'(stall), 1);
      nxt();
    end
    mid();
    chk("raw_c4_stall", 32'(stall), 0);

    // Independent non-writing ADD runs under the FPU, stalls only in WB
    nxt(); set_id(OP_ADDF, 4'd1, 4'd3, 4'd2);
    mid();
    if (fpu_start === 1'b1) sb.push_back(4'd2);
    chk("indep_start", 32'(fpu_start), 1);
    nxt(); set_id(OP_ADDNW, 4'd4, 4'd0, 4'd2);
    for (int c = 1; c <= 2; c++) begin
      mid();
      chk($sformatf("indep_c%0d_stall", c), 32'(stall), 0);
      nxt();
    end
    mid();
    chk("indep_wb_stall", 32'(stall), 1);

    // Load-use: one cycle, then EX holds the inserted NOP
    nxt(); set_id(OP_SUB, 4'd0, 4'd7, 4'd1); set_ex(OP_LOAD, 4'd7);
    mid();
    chk("lu_stall", 32'(stall), 1);
    nxt(); set_ex(OP_NONE, 4'd0);
    mid();
    chk("lu_release", 32'(stall), 0);
    nxt(); set_id(OP_MOVEI, 4'd7, 4'd7, 4'd1); set_ex(OP_LOAD, 4'd7);
    mid();
    chk("lu_movei", 32'(stall), 0);
    set_id(OP_NOP, 4'd7, 4'd7, 4'd7);
    #1;
    chk("lu_nop", 32'(stall), 0);
    set_id(OP_NONE, 4'd7, 4'd7, 4'd7);
    #1;
    chk("lu_zero_op", 32'(stall), 0);
    chk("lu_zero_start", 32'(fpu_start), 0);

    // Structural hazard: MULF waits behind ADDF, then WAW against that MULF
    nxt(); set_ex(OP_NONE, 4'd0); set_id(OP_ADDF, 4'd1, 4'd1, 4'd8);
    mid();
    if (fpu_start === 1'b1) sb.push_back(4'd8);
    chk("str_addf_start", 32'(fpu_start), 1);
    nxt(); set_id(OP_MULF, 4'd1, 4'd1, 4'd9);
    for (int c = 1; c <= 3; c++) begin
      mid();
      chk($sformatf("str_c%0d_stall", c), 32'(stall), 1);
      chk($sformatf("str_c%0d_start", c), 32'(fpu_start), 0);
      nxt();
    end
    mid();
    chk("str_issue_stall", 32'(stall), 0);
    chk("str_issue_start", 32'(fpu_start), 1);
    chk("str_issue_sel", 32'(fpu_mul), 1);
    if (fpu_start === 1'b1) sb.push_back(4'd9);
    nxt(); set_id(OP_MOVE, 4'd1, 4'd0, 4'd9);
    for (int c = 1; c <= 5; c++) begin
      mid();
      chk($sformatf("waw_c%0d_stall", c), 32'(stall), 1);
      nxt();
    end
    mid();
    chk("waw_release", 32'(stall), 0);

    // ADDF delayed one cycle by a load-use hazard
    nxt(); set_ex(OP_LOAD, 4'd4); set_id(OP_ADDF, 4'd4, 4'd1, 4'd11);
    mid();
    chk("lu_fp_stall", 32'(stall), 1);
    chk("lu_fp_start", 32'(fpu_start), 0);
    nxt(); set_ex(OP_NONE, 4'd0);
    mid();
    chk("lu_fp_issue_stall", 32'(stall), 0);
    chk("lu_fp_issue_start", 32'(fpu_start), 1);
    if (fpu_start === 1'b1) sb.push_back(4'd11);
    nxt(); set_id(OP_NONE, 4'd0, 4'd0, 4'd0);
    repeat (3) nxt();

    // Both FP bits set behaves as MULF (writeback at cycle 5, not 3)
    set_id(OP_BOTHF, 4'd0, 4'd0, 4'd12);
    mid();
    chk("both_sel", 32'(fpu_mul), 1);
    if (fpu_start === 1'b1) sb.push_back(4'd12);
    nxt(); set_id(OP_NONE, 4'd0, 4'd0, 4'd0);
    nxt(); nxt();
    mid();
    chk("both_c3_wb", 32'(fpu_wb_en), 0);
    nxt(); nxt();
    mid();
    chk("both_c5_wb", 32'(fpu_wb_en), 1);

    // Reset in the second BUSY cycle discards the ADDF to r3
    nxt(); set_id(OP_ADDF, 4'd0, 4'd0, 4'd3);
    nxt(); set_id(OP_ADD, 4'd3, 4'd0, 4'd1);
    nxt();
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_busy");
    nxt();
    reset_n = 1'b1;
    set_id(OP_NONE, 4'd0, 4'd0, 4'd0);
    for (int c = 0; c < 4; c++) begin
      mid();
      chk($sformatf("rst_after_c%0d_busy", c), 32'(fpu_busy), 0);
      nxt();
    end
    set_id(OP_ADDF, 4'd0, 4'd0, 4'd13);
    mid();
    chk("rst_idle_start", 32'(fpu_start), 1);
    if (fpu_start === 1'b1) sb.push_back(4'd13);
    nxt(); set_id(OP_NONE, 4'd0, 4'd0, 4'd0);
    repeat (5) nxt();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
